// File: rtl/evt_host_link.sv
// evt_host_link: UART host-link layer. Assembles event words into a FIFO,
// decodes host commands and serialises reports through a TX byte FIFO.
module evt_host_link #(
  parameter int         WORD_BYTES     = 4,
  parameter int         EVT_FIFO_DEPTH = 16,
  parameter int         TX_FIFO_DEPTH  = 8,
  parameter int         TIMEOUT_CLKS   = 1250,
  parameter logic [7:0] CFG_BYTE0      = 8'd20,
  parameter logic [7:0] CFG_BYTE1      = 8'd8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_busy,
  output logic [8*WORD_BYTES-1:0] evt_word,
  output logic                    evt_valid,
  input  logic                    evt_ready,
  input  logic [1:0]              gesture,
  input  logic                    gesture_valid,
  input  logic [3:0]              gesture_confidence,
  input  logic [7:0]              event_count,
  input  logic [3:0]              status_flags,
  output logic                    soft_rst,
  output logic [15:0]             drop_count,
  output logic [7:0]              resync_count,
  output logic [7:0]              tx_ovf_count
);
  localparam int WW  = 8 * WORD_BYTES;
  localparam int IXW = $clog2(WORD_BYTES + 1);
  localparam int EAW = $clog2(EVT_FIFO_DEPTH);
  localparam int TAW = $clog2(TX_FIFO_DEPTH);
  localparam int TOW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [TOW-1:0] TO_LAST =
    TOW'((TIMEOUT_CLKS > 0) ? TIMEOUT_CLKS - 1 : 0);

  typedef enum logic [1:0] {T_IDLE, T_WAIT_HI, T_WAIT_LO} tx_state_t;

  logic [IXW-1:0] r_idx;
  logic [WW-1:0]  r_word;
  logic [WW-1:0]  r_push_word;
  logic           r_push_pend;
  logic [TOW-1:0] r_idle;
  logic           r_soft;
  logic [15:0]    r_drop;
  logic [7:0]     r_resync;
  logic [7:0]     r_ovf;

  logic           w_cmd;
  logic           w_data;
  logic           w_last;
  logic           w_timeout;
  logic [WW-1:0]  w_word_nxt;

  assign w_cmd      = rx_valid && (r_idx == '0) && (rx_data[7:2] == 6'h3F);
  assign w_data     = rx_valid && !w_cmd;
  assign w_last     = (r_idx == IXW'(WORD_BYTES - 1));
  assign w_word_nxt = {r_word[WW-9:0], rx_data};
  assign w_timeout  = (TIMEOUT_CLKS != 0) && !rx_valid &&
                      (r_idx != '0) && (r_idle == TO_LAST);

  // Completed word is parked one cycle so a back-to-back byte can't corrupt it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx       <= '0;
      r_word      <= '0;
      r_push_word <= '0;
      r_push_pend <= 1'b0;
      r_idle      <= '0;
    end else if (r_soft) begin
      r_idx       <= '0;
      r_push_pend <= 1'b0;
      r_idle      <= '0;
    end else begin
      r_push_pend <= 1'b0;
      if (w_data) begin
        r_word <= w_word_nxt;
        if (w_last) begin
          r_idx       <= '0;
          r_push_pend <= 1'b1;
          r_push_word <= w_word_nxt;
        end else begin
          r_idx <= r_idx + IXW'(1);
        end
      end else if (w_timeout) begin
        r_idx <= '0;
      end
      if (rx_valid || (r_idx == '0) || w_timeout) r_idle <= '0;
      else r_idle <= r_idle + TOW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_soft <= 1'b0;
    else r_soft <= w_cmd && (rx_data[1:0] == 2'b00) && !r_soft;
  end

  logic [WW-1:0]  r_emem [EVT_FIFO_DEPTH];
  logic [EAW-1:0] r_ewp;
  logic [EAW-1:0] r_erp;
  logic [EAW:0]   r_ecnt;
  logic           w_efull;
  logic           w_epop;
  logic           w_epush;
  logic           w_edrop;

  assign evt_valid = (r_ecnt != '0);
  assign evt_word  = evt_valid ? r_emem[r_erp] : '0;
  assign w_efull   = (r_ecnt == (EAW+1)'(EVT_FIFO_DEPTH));
  assign w_epop    = evt_valid && evt_ready && !r_soft;
  assign w_epush   = r_push_pend && !r_soft && (!w_efull || w_epop);
  assign w_edrop   = r_push_pend && !r_soft && !w_epush;

  always_ff @(posedge clk) begin
    if (w_epush) r_emem[r_ewp] <= r_push_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ewp  <= '0;
      r_erp  <= '0;
      r_ecnt <= '0;
    end else if (r_soft) begin
      r_ewp  <= '0;
      r_erp  <= '0;
      r_ecnt <= '0;
    end else begin
      if (w_epush) r_ewp <= r_ewp + EAW'(1);
      if (w_epop) r_erp <= r_erp + EAW'(1);
      r_ecnt <= r_ecnt + (EAW+1)'(w_epush) - (EAW+1)'(w_epop);
    end
  end

  logic       r_g_pend;
  logic [7:0] r_g_b0;
  logic [7:0] r_g_b1;
  logic       r_c_pend;
  logic       r_c_two;
  logic [7:0] r_c_b0;
  logic [7:0] r_c_b1;
  logic       r_enq_busy;
  logic [7:0] r_enq_b1;

  logic [TAW:0] r_tcnt;
  logic [TAW:0] w_tfree;
  logic         w_tpush;
  logic [7:0]   w_tbyte;
  logic         w_g_take;
  logic         w_c_take;
  logic         w_ovf;
  logic         w_start2;
  logic [7:0]   w_b1;

  assign w_tfree = (TAW+1)'(TX_FIFO_DEPTH) - r_tcnt;

  // Gesture wins; a started 2-byte message owns the next write slot
  always_comb begin
    w_tpush  = 1'b0;
    w_tbyte  = r_enq_b1;
    w_g_take = 1'b0;
    w_c_take = 1'b0;
    w_ovf    = 1'b0;
    w_start2 = 1'b0;
    w_b1     = r_enq_b1;
    if (r_enq_busy) begin
      w_tpush = 1'b1;
    end else if (r_g_pend) begin
      w_g_take = 1'b1;
      if (w_tfree >= (TAW+1)'(2)) begin
        w_tpush  = 1'b1;
        w_tbyte  = r_g_b0;
        w_start2 = 1'b1;
        w_b1     = r_g_b1;
      end else begin
        w_ovf = 1'b1;
      end
    end else if (r_c_pend) begin
      w_c_take = 1'b1;
      if (w_tfree >= (r_c_two ? (TAW+1)'(2) : (TAW+1)'(1))) begin
        w_tpush  = 1'b1;
        w_tbyte  = r_c_b0;
        w_start2 = r_c_two;
        w_b1     = r_c_b1;
      end else begin
        w_ovf = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_g_pend   <= 1'b0;
      r_g_b0     <= '0;
      r_g_b1     <= '0;
      r_c_pend   <= 1'b0;
      r_c_two    <= 1'b0;
      r_c_b0     <= '0;
      r_c_b1     <= '0;
      r_enq_busy <= 1'b0;
      r_enq_b1   <= '0;
    end else if (r_soft) begin
      r_g_pend   <= 1'b0;
      r_c_pend   <= 1'b0;
      r_enq_busy <= 1'b0;
    end else begin
      r_enq_busy <= w_start2;
      r_enq_b1   <= w_b1;
      if (w_g_take) r_g_pend <= 1'b0;
      if (gesture_valid) begin
        r_g_pend <= 1'b1;
        r_g_b0   <= {4'hA, 2'b00, gesture};
        r_g_b1   <= {gesture_confidence, event_count[7:4]};
      end
      if (w_c_take) r_c_pend <= 1'b0;
      if (w_cmd && (rx_data[1:0] != 2'b00)) begin
        r_c_pend <= 1'b1;
        case (rx_data[1:0])
          2'b11: begin
            r_c_two <= 1'b0;
            r_c_b0  <= 8'h55;
          end
          2'b10: begin
            r_c_two <= 1'b0;
            r_c_b0  <= {4'hB, status_flags};
          end
          default: begin
            r_c_two <= 1'b1;
            r_c_b0  <= CFG_BYTE0;
            r_c_b1  <= CFG_BYTE1;
          end
        endcase
      end
    end
  end

  logic [7:0]   r_tmem [TX_FIFO_DEPTH];
  logic [TAW-1:0] r_twp;
  logic [TAW-1:0] r_trp;
  tx_state_t    r_tst;
  tx_state_t    w_tst_nxt;
  logic         w_tpop;
  logic         r_tx_valid;
  logic [7:0]   r_tx_data;

  always_comb begin
    w_tst_nxt = r_tst;
    w_tpop    = 1'b0;
    unique case (r_tst)
      T_IDLE: begin
        if ((r_tcnt != '0) && !tx_busy) begin
          w_tpop    = 1'b1;
          w_tst_nxt = T_WAIT_HI;
        end
      end
      T_WAIT_HI: if (tx_busy) w_tst_nxt = T_WAIT_LO;
      T_WAIT_LO: if (!tx_busy) w_tst_nxt = T_IDLE;
      default: w_tst_nxt = T_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_tpush && !r_soft) r_tmem[r_twp] <= w_tbyte;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_twp      <= '0;
      r_trp      <= '0;
      r_tcnt     <= '0;
      r_tst      <= T_IDLE;
      r_tx_valid <= 1'b0;
      r_tx_data  <= '0;
    end else if (r_soft) begin
      r_twp      <= '0;
      r_trp      <= '0;
      r_tcnt     <= '0;
      r_tst      <= T_IDLE;
      r_tx_valid <= 1'b0;
    end else begin
      r_tst      <= w_tst_nxt;
      r_tx_valid <= w_tpop;
      if (w_tpop) r_tx_data <= r_tmem[r_trp];
      if (w_tpush) r_twp <= r_twp + TAW'(1);
      if (w_tpop) r_trp <= r_trp + TAW'(1);
      r_tcnt <= r_tcnt + (TAW+1)'(w_tpush) - (TAW+1)'(w_tpop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop   <= '0;
      r_resync <= '0;
      r_ovf    <= '0;
    end else begin
      if (w_edrop && (r_drop != '1)) r_drop <= r_drop + 16'd1;
      if (w_timeout && !r_soft && (r_resync != '1))
        r_resync <= r_resync + 8'd1;
      if (w_ovf && !r_soft && (r_ovf != '1)) r_ovf <= r_ovf + 8'd1;
    end
  end

  assign tx_valid     = r_tx_valid;
  assign tx_data      = r_tx_data;
  assign soft_rst     = r_soft;
  assign drop_count   = r_drop;
  assign resync_count = r_resync;
  assign tx_ovf_count = r_ovf;
endmodule

// File: tb/tb_evt_host_link.sv
// tb_evt_host_link: directed bench for evt_host_link with a simple
// UART TX responder that raises tx_busy after every send strobe.
module tb_evt_host_link;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_busy;
  logic [31:0] evt_word;
  logic        evt_valid;
  logic        evt_ready = 1'b0;
  logic [1:0]  gesture = '0;
  logic        gesture_valid = 1'b0;
  logic [3:0]  gesture_confidence = '0;
  logic [7:0]  event_count = '0;
  logic [3:0]  status_flags = '0;
  logic        soft_rst;
  logic [15:0] drop_count;
  logic [7:0]  resync_count;
  logic [7:0]  tx_ovf_count;

  int checks = 0;
  int failures = 0;
  int n0 = 0;
  logic force_busy = 1'b0;
  int busy_cnt = 0;
  int b2b = 0;
  logic prev_v = 1'b0;
  logic [7:0] txq[$];

  always #5 clk = ~clk;
  assign tx_busy = force_busy | (busy_cnt > 0);

  evt_host_link dut (
    .clk(clk), .rst_n(rst_n),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_busy(tx_busy),
    .evt_word(evt_word), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .gesture(gesture), .gesture_valid(gesture_valid),
    .gesture_confidence(gesture_confidence),
    .event_count(event_count), .status_flags(status_flags),
    .soft_rst(soft_rst), .drop_count(drop_count),
    .resync_count(resync_count), .tx_ovf_count(tx_ovf_count)
  );

  always @(negedge clk) begin
    if (tx_valid) begin
      txq.push_back(tx_data);
      busy_cnt = 3;
      if (prev_v) b2b++;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
    end
    prev_v = tx_valid;
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send(w[31:24]);
    send(w[23:16]);
    send(w[15:8]);
    send(w[7:0]);
  endtask

  task automatic pop_word(input string tag, input logic [31:0] exp);
    int n = 0;
    while (!evt_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'({evt_valid, evt_word}), 64'({1'b1, exp}));
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;
  endtask

  task automatic wait_tx(input int n);
    int k = 0;
    while (txq.size() < n && k < 300) begin
      @(negedge clk);
      k++;
    end
  endtask

  initial begin
    tick(3);
    rst_n = 1'b1;
    tick(2);
    send(8'h12);
    #2 rst_n = 1'b0;
    #1 chk("rst_async_out", 64'({evt_valid, soft_rst, tx_valid}), 64'(0));
    tick(2);
    rst_n = 1'b1;
    tick(2);
    chk("rst_evt", 64'({evt_valid, evt_word}), 64'(0));
    chk("rst_cnt", 64'({drop_count, resync_count, tx_ovf_count}), 64'(0));
    chk("rst_out", 64'({soft_rst, tx_valid, tx_data}), 64'(0));
    send_word(32'h12345678);
    tick(3);
    pop_word("rst_word", 32'h12345678);

    for (int k = 1; k <= 17; k++)
      send_word({8'(k), 8'h5A, 8'(k * 3), 8'hC3});
    tick(3);
    chk("ovf_drop", 64'(drop_count), 64'(1));
    for (int k = 1; k <= 16; k++)
      pop_word("ovf_order", {8'(k), 8'h5A, 8'(k * 3), 8'hC3});
    tick(2);
    chk("ovf_empty", 64'(evt_valid), 64'(0));

    send(8'hAB);
    send(8'hCD);
    tick(1260);
    chk("to_resync", 64'(resync_count), 64'(1));
    n0 = txq.size();
    send(8'hFF);
    wait_tx(n0 + 1);
    chk("to_tx55", 64'(txq[n0]), 64'(8'h55));
    chk("to_no_word", 64'(evt_valid), 64'(0));
    send(8'h11);
    send(8'h22);
    tick(1200);
    send(8'h33);
    send(8'h44);
    tick(3);
    pop_word("to_keep_word", 32'h11223344);
    chk("to_resync_kept", 64'(resync_count), 64'(1));

    tick(20);
    n0 = txq.size();
    send(8'h01);
    send(8'hFF);
    send(8'hFE);
    send(8'hFD);
    tick(20);
    pop_word("cmd_as_data", 32'h01FFFEFD);
    chk("cmd_no_tx", 64'(txq.size()), 64'(n0));

    n0 = txq.size();
    @(negedge clk);
    rx_data = 8'hFD;
    rx_valid = 1'b1;
    gesture = 2'd2;
    gesture_confidence = 4'd9;
    event_count = 8'h5C;
    gesture_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    gesture_valid = 1'b0;
    wait_tx(n0 + 4);
    chk("pri_b0", 64'(txq[n0]), 64'(8'hA2));
    chk("pri_b1", 64'(txq[n0+1]), 64'(8'h95));
    chk("pri_b2", 64'(txq[n0+2]), 64'(8'h14));
    chk("pri_b3", 64'(txq[n0+3]), 64'(8'h08));

    n0 = txq.size();
    status_flags = 4'h7;
    send(8'hFE);
    status_flags = 4'h0;
    wait_tx(n0 + 1);
    chk("status_rsp", 64'(txq[n0]), 64'(8'hB7));

    tick(30);
    force_busy = 1'b1;
    tick(2);
    send_word(32'hCAFE0001);
    tick(3);
    chk("sr_pre_evt", 64'(evt_valid), 64'(1));
    n0 = txq.size();
    for (int g = 0; g < 5; g++) begin
      @(negedge clk);
      gesture = 2'(g);
      gesture_confidence = 4'(g + 1);
      gesture_valid = 1'b1;
      @(negedge clk);
      gesture_valid = 1'b0;
      tick(4);
    end
    chk("sr_ovf_count", 64'(tx_ovf_count), 64'(1));
    @(negedge clk);
    rx_data = 8'hFC;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    chk("sr_pulse_hi", 64'(soft_rst), 64'(1));
    @(negedge clk);
    chk("sr_pulse_lo", 64'(soft_rst), 64'(0));
    chk("sr_evt_empty", 64'(evt_valid), 64'(0));
    chk("sr_cnt_kept", 64'({drop_count, resync_count, tx_ovf_count}),
        64'({16'd1, 8'd1, 8'd1}));
    force_busy = 1'b0;
    tick(50);
    chk("sr_tx_empty", 64'(txq.size()), 64'(n0));
    send_word(32'h0A0B0C0D);
    tick(3);
    pop_word("sr_after_word", 32'h0A0B0C0D);
    chk("tx_no_b2b", 64'(b2b), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/evt_host_link.md
Name: evt_host_link

Overview:
- Parametrised UART host-link layer between the byte-level UART RX/TX and the gesture classifier core.
- Assembles multi-byte event words (MSB first) into a buffered event FIFO, so words are no longer dropped while the core stalls.
- Resynchronises partial words on an inter-byte timeout and decodes host commands.
- Serialises gesture reports and command responses through a TX byte FIFO, with atomic message enqueue and drop/overflow statistics.

Parameters:
- WORD_BYTES, 4: bytes per event word; range 2..8.
- EVT_FIFO_DEPTH, 16: event word FIFO depth; power of 2, at least 2.
- TX_FIFO_DEPTH, 8: TX byte FIFO depth; power of 2, at least 4.
- TIMEOUT_CLKS, 1250: idle clocks after which a partial word is discarded; 0 disables the timeout.
- CFG_BYTE0, 20: first config response byte.
- CFG_BYTE1, 8: second config response byte.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- rx_data  in  8  received UART byte.
- rx_valid  in  1  one-cycle strobe; rx_data is valid.
- tx_data  out  8  byte to UART TX.
- tx_valid  out  1  one-cycle send strobe.
- tx_busy  in  1  UART TX is shifting.
- evt_word  out  8*WORD_BYTES  head of the event FIFO.
- evt_valid  out  1  event FIFO is not empty.
- evt_ready  in  1  core accepts evt_word.
- gesture  in  2  classified direction.
- gesture_valid  in  1  one-cycle detection strobe.
- gesture_confidence  in  4  confidence of the detection.
- event_count  in  8  core event count.
- status_flags  in  4  core status bits for the status response.
- soft_rst  out  1  one-cycle soft-reset pulse.
- drop_count  out  16  saturating count of event words dropped because the event FIFO was full.
- resync_count  out  8  saturating count of timeout discards.
- tx_ovf_count  out  8  saturating count of messages dropped because the TX FIFO lacked space.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All outputs are 0; both FIFOs are empty; the assembler is at byte index 0; all counters are 0; the TX FSM is in T_IDLE.
- Assembler:
  - At byte index 0, the command bytes 0xFF, 0xFE, 0xFD and 0xFC are consumed as commands and never start a word.
  - Any other byte is loaded into the MS byte and the index advances.
  - Command values appearing at index 1 or higher are treated as data.
  - After WORD_BYTES bytes the word is complete. On the edge after the last byte it is pushed into the event FIFO if the FIFO is not full; otherwise it is dropped and drop_count increments.
  - In both cases the index returns to 0.
- Timeout:
  - The idle counter clears on every rx_valid.
  - If the index is not 0 and the counter reaches TIMEOUT_CLKS, the index returns to 0, the partial word is discarded and resync_count increments.
  - No timeout action occurs while the index is 0.
- Event FIFO:
  - First-word fall-through: evt_valid = !empty and evt_word = head.
  - Pop on evt_valid && evt_ready.
  - A simultaneous push and pop when full is allowed: the count is unchanged and nothing is dropped.
- Commands:
  - 0xFF queues the 1-byte message 0x55.
  - 0xFE queues {4'hB, status_flags}; status_flags is sampled on the rx edge.
  - 0xFD queues the 2-byte message CFG_BYTE0, CFG_BYTE1.
  - 0xFC pulses soft_rst for one cycle. On the following edge both FIFOs, the assembler, the pending registers and the TX FSM clear. Counters are retained.
- Pending registers:
  - One command-pending register and one gesture-pending register.
  - A new command arriving while a command is pending overwrites it.
  - gesture_valid captures {gesture, gesture_confidence, event_count[7:4]} into the gesture-pending register, overwriting any earlier capture.
- Enqueue arbiter:
  - Enqueues at most one message per cycle; gesture has priority over command.
  - A message is written atomically, one byte per cycle, only if the free space is at least the message length.
  - If space is insufficient, the message is discarded, its pending flag is cleared and tx_ovf_count increments.
  - Gesture message: {4'hA, 2'b00, gesture}, then {confidence, event_count[7:4]}.
- TX FSM:
  - T_IDLE: if the FIFO is not empty and tx_busy = 0, pop, drive tx_data, pulse tx_valid and go to T_WAIT_HI.
  - T_WAIT_HI: wait for tx_busy = 1, then go to T_WAIT_LO.
  - T_WAIT_LO: wait for tx_busy = 0, then go to T_IDLE.
  - Between any two tx_valid strobes there are therefore at least 2 cycles.
- Counters saturate at their all-ones value and never wrap.

Test Plan:
- Reset value: assert rst_n low mid-word, then release → evt_valid = 0, all counters 0, the next 4 bytes 0x12 0x34 0x56 0x78 yield evt_word = 0x12345678.
- Event FIFO overflow: hold evt_ready = 0 and send 17 words with EVT_FIFO_DEPTH = 16 → 16 words buffered in order, drop_count = 1; releasing evt_ready drains words 1..16 in order.
- Timeout resync: send 0xAB 0xCD, idle TIMEOUT_CLKS cycles, then send 0xFF → resync_count = 1 and TX emits 0x55.
- Command vs data: send 0x01, then 0xFF 0xFE 0xFD → assembled word 0x01FFFEFD and no TX output.
- Priority and atomicity: gesture_valid (gesture = 2, confidence = 9, event_count = 0x5C) in the same cycle as 0xFD → TX bytes 0xA2, 0x95, 0x14, 0x08.
- TX overflow and soft reset: with tx_busy held 1 and TX_FIFO_DEPTH = 8, issue five gestures → the fifth increments tx_ovf_count; sending 0xFC then gives a one-cycle soft_rst and both FIFOs empty with counters retained.
